viewport_scanner: RTL
=====================

# viewport_scanner

Parametrised, streaming successor to the per-index linear scaler. On a start command it walks every pixel of an X_RES × Y_RES viewport in raster order and emits one complex-plane coordinate pair (re, im) per accepted beat over a valid/ready handshake, computed by exact fixed-point accumulation rather than a per-pixel multiply. It sits between the viewport/zoom control registers and the Mandelbrot iteration pipeline, feeding it coordinates at up to one pixel per clock.

## Interface
- COORD_W, 64, coordinate width in bits, two's complement.
- FRAC_W, 56, fractional bits of every coordinate; the format is Q(COORD_W−FRAC_W).FRAC_W.
- X_RES, 640, pixels per row, ≥ 1.
- Y_RES, 480, rows per frame, ≥ 1.
- XW, $clog2(X_RES) (min 1), derived width of the x index.
- YW, $clog2(Y_RES) (min 1), derived width of the y index.

- clock  input  1  sole clock; everything updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a frame; sampled only in IDLE.
- x_offset  input  COORD_W  re of pixel (0, y).
- x_step  input  COORD_W  re increment per column.
- y_offset  input  COORD_W  im of row 0.
- y_step  input  COORD_W  im increment per row.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the final pixel is accepted.
- out_valid  output  1  out_* hold a valid pixel.
- out_ready  input  1  downstream accepts the pixel this cycle.
- out_re  output  COORD_W  real coordinate.
- out_im  output  COORD_W  imaginary coordinate.
- out_x  output  XW  column index.
- out_y  output  YW  row index.
- out_last  output  1  high with the final pixel of the frame.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in IDLE with start=1, latch x_offset, x_step, y_offset and y_step, set x=0, y=0, re=x_offset, im=y_offset, and go to RUN. Offset/step inputs may change freely after that start cycle.
- RUN: out_valid=1. A beat transfers when out_valid and out_ready are both 1.
- On transfer, when x is not the end of the row: x advances, re += x_step (or −= in the reversed rows described under Configuration).
- On transfer at the end of a row with y < Y_RES−1: x returns to the row start, re returns to the latched x_offset, y += 1, im += y_step.
- On transfer of the final pixel (out_last=1): go to DONE.
- DONE: lasts one cycle with done=1, then goes to IDLE.
- Arithmetic: all additions are modulo 2^COORD_W (wrap, no saturation).
- Accumulated values must equal offset + k·step mod 2^COORD_W exactly, so there is no drift.
- start is ignored in RUN and DONE. It is not queued.
- reset in any state: go to IDLE. busy, done and out_valid are 0 on the next cycle, and the in-flight frame is discarded.
- Degenerate sizes: X_RES=1 and/or Y_RES=1 must work. For a 1×1 frame, the single pixel has out_last=1.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_re=0, out_im=0, out_x=0, out_y=0.
- Latency: start sampled at edge N gives out_valid=1 with pixel (0,0) at N+1.
- Throughput: with out_ready held at 1, one pixel per cycle. A frame occupies exactly X_RES·Y_RES cycles of RUN.
- Back-pressure: while out_valid=1 and out_ready=0, all out_* stay stable. out_valid never drops before its transfer.
- busy: 1 from the cycle after start through the cycle of the final transfer.
- Final transfer at edge M: done=1 and busy=0 in cycle M+1. The earliest new start is sampled at edge M+2.
- out_last is registered with the pixel and is stable under back-pressure.

## Configuration
- SCANNER_SERPENTINE_EN defined: odd rows run right-to-left.
  - The row starts at x=X_RES−1 with re = x_offset + (X_RES−1)·x_step, which is kept in a register precomputed at start.
  - Each step does re −= x_step and x −= 1.
  - The row ends at x=0.
  - Each (x, y) still carries re = x_offset + x·x_step.
- SCANNER_SERPENTINE_EN undefined: every row runs left-to-right, and out_last is pixel (X_RES−1, Y_RES−1).

## Test plan
Common setup: COORD_W=16, FRAC_W=8, X_RES=4, Y_RES=3; x_offset=0xFE00 (−2.0), x_step=0x0080 (0.5), y_offset=0x0100 (1.0), y_step=0xFFC0 (−0.25).

- Raster run, out_ready=1, macro off:
  - (0,0) = re 0xFE00, im 0x0100, one cycle after start.
  - (3,0) has re 0xFF80.
  - (0,2) has im 0x0080.
  - 12 beats on consecutive cycles.
  - out_last only on (3,2): re 0xFF80, im 0x0080.
  - done pulses one cycle later.
- Random out_ready (~50%): outputs stable whenever ready=0, and the same 12-pixel sequence as the raster run.
- start pulsed mid-frame with different offsets: ignored, and the frame completes with the original values.
- reset asserted at beat 5: busy, out_valid and done all 0 the next cycle. A later start restarts at (0,0), re 0xFE00.
- Wrap: x_offset=0x7F00, x_step=0x0100 gives re sequence 0x7F00, 0x8000, 0x8100, 0x8200.
- Macro on: row 1 order is x=3,2,1,0 with re 0xFF80, 0xFF00, 0xFE80, 0xFE00. out_last is (3,2).

Source files
------------

// File: rtl/viewport_scanner_if.sv
// Pixel stream carrying one complex-plane coordinate per beat from viewport_scanner to the
// Mandelbrot iteration pipeline. The beat moves on a cycle where out_valid and out_ready are both 1.
//   out_valid  master->slave  out_* hold a valid pixel
//   out_ready  slave->master  downstream accepts the pixel this cycle
//   out_re     master->slave  real coordinate, Q(COORD_W-FRAC_W).FRAC_W
//   out_im     master->slave  imaginary coordinate
//   out_x      master->slave  column index
//   out_y      master->slave  row index
//   out_last   master->slave  final pixel of the frame
interface viewport_scanner_if #(
  parameter int COORD_W = 64,
  parameter int X_RES   = 640,
  parameter int Y_RES   = 480
);
  localparam int XW = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int YW = (Y_RES > 1) ? $clog2(Y_RES) : 1;

  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_re;
  logic [COORD_W-1:0] out_im;
  logic [XW-1:0]      out_x;
  logic [YW-1:0]      out_y;
  logic               out_last;

  modport master (
    output out_valid, out_re, out_im, out_x, out_y, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_re, out_im, out_x, out_y, out_last,
    output out_ready
  );
endinterface

// File: rtl/viewport_scanner.sv
// viewport_scanner: on start, walks an X_RES x Y_RES viewport in raster order and streams one
// (re, im) coordinate pair per accepted beat. Coordinates are built by exact modular accumulation
// of the latched step values, so every pixel equals offset + k*step mod 2^COORD_W.
//
// Optional feature macro: SCANNER_SERPENTINE_EN -- odd rows are scanned right-to-left; each
// (x, y) still carries re = x_offset + x*x_step.
//
// Ports:
//   clock     sole clock, rising edge
//   reset     synchronous active-high reset
//   start     begin a frame (sampled only while idle)
//   x_offset  re of column 0;  x_step  re increment per column
//   y_offset  im of row 0;     y_step  im increment per row
//   busy      a frame is in progress
//   done      one-cycle pulse after the final pixel is accepted
//   out       pixel stream (viewport_scanner_if.master)
module viewport_scanner #(
  parameter int COORD_W = 64,
  parameter int FRAC_W  = 56,
  parameter int X_RES   = 640,
  parameter int Y_RES   = 480
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x_offset,
  input  logic [COORD_W-1:0] x_step,
  input  logic [COORD_W-1:0] y_offset,
  input  logic [COORD_W-1:0] y_step,
  output logic               busy,
  output logic               done,
  viewport_scanner_if.master out
);

  localparam int XW = (X_RES > 1) ? $clog2(X_RES) : 1;
  localparam int YW = (Y_RES > 1) ? $clog2(Y_RES) : 1;

  localparam logic [XW-1:0] XLast = XW'(X_RES - 1);
  localparam logic [YW-1:0] YLast = YW'(Y_RES - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Elaboration-time sanity check of the configuration.
  if (FRAC_W < 0 || FRAC_W > COORD_W || X_RES < 1 || Y_RES < 1) begin : g_bad_cfg
    $error("viewport_scanner: invalid parameter combination");
  end

  logic [1:0]         state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [COORD_W-1:0] re_q, re_d;
  logic [COORD_W-1:0] im_q, im_d;
  logic [COORD_W-1:0] xoff_q, xoff_d;
  logic [COORD_W-1:0] xstep_q, xstep_d;
  logic [COORD_W-1:0] ystep_q, ystep_d;
  logic               last_q, last_d;
  logic               rev_row;
  logic               row_end;

`ifdef SCANNER_SERPENTINE_EN
  // re of column X_RES-1, the entry point of every reversed row.
  logic [COORD_W-1:0] rend_q, rend_d;
  assign rev_row = y_q[0];
`else
  assign rev_row = 1'b0;
`endif

  // True when (x, y) is the final pixel of the frame in scan order.
  function automatic logic is_last(input logic [XW-1:0] x, input logic [YW-1:0] y);
`ifdef SCANNER_SERPENTINE_EN
    return (y == YLast) && (x == (y[0] ? '0 : XLast));
`else
    return (y == YLast) && (x == XLast);
`endif
  endfunction

  assign row_end = rev_row ? (x_q == '0) : (x_q == XLast);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    re_d    = re_q;
    im_d    = im_q;
    xoff_d  = xoff_q;
    xstep_d = xstep_q;
    ystep_d = ystep_q;
    last_d  = last_q;
`ifdef SCANNER_SERPENTINE_EN
    rend_d  = rend_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          xoff_d  = x_offset;
          xstep_d = x_step;
          ystep_d = y_step;
`ifdef SCANNER_SERPENTINE_EN
          rend_d  = x_offset + COORD_W'(X_RES - 1) * x_step;
`endif
          x_d     = '0;
          y_d     = '0;
          re_d    = x_offset;
          im_d    = y_offset;
          last_d  = is_last('0, '0);
          state_d = StRun;
        end
      end
      StRun: begin
        if (out.out_ready) begin
          if (!row_end) begin
            if (rev_row) begin
              x_d  = x_q - XW'(1);
              re_d = re_q - xstep_q;
            end else begin
              x_d  = x_q + XW'(1);
              re_d = re_q + xstep_q;
            end
          end else if (y_q != YLast) begin
            y_d  = y_q + YW'(1);
            im_d = im_q + ystep_q;
`ifdef SCANNER_SERPENTINE_EN
            // Leaving an even row means entering an odd (reversed) one.
            if (!y_q[0]) begin
              x_d  = XLast;
              re_d = rend_q;
            end else begin
              x_d  = '0;
              re_d = xoff_q;
            end
`else
            x_d  = '0;
            re_d = xoff_q;
`endif
          end else begin
            state_d = StDone;
          end
          last_d = (state_d == StRun) && is_last(x_d, y_d);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      re_q    <= '0;
      im_q    <= '0;
      xoff_q  <= '0;
      xstep_q <= '0;
      ystep_q <= '0;
      last_q  <= 1'b0;
`ifdef SCANNER_SERPENTINE_EN
      rend_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      re_q    <= re_d;
      im_q    <= im_d;
      xoff_q  <= xoff_d;
      xstep_q <= xstep_d;
      ystep_q <= ystep_d;
      last_q  <= last_d;
`ifdef SCANNER_SERPENTINE_EN
      rend_q  <= rend_d;
`endif
    end
  end

  assign busy          = (state_q == StRun);
  assign done          = (state_q == StDone);
  assign out.out_valid = (state_q == StRun);
  assign out.out_re    = re_q;
  assign out.out_im    = im_q;
  assign out.out_x     = x_q;
  assign out.out_y     = y_q;
  assign out.out_last  = last_q;

endmodule
